y86_decode_stage: RTL and testbench

//  Pipelined decode/register-file stage for the Y86-64 core, succeeding the combinational srcA/srcB selector.

---
 rtl/y86_decode_stage.sv | 192 +++++++++++++++++++
 tb/tb_y86_decode_stage.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/y86_decode_stage.sv
// y86_decode_stage
//   Decode / register-file stage of the pipelined Y86-64 core. Picks srcA/srcB/dstE/dstM from
//   icode/rA/rB, reads a 2R/2W register file with write-to-read bypass from writeback, and loads
//   the result into the D->E pipeline register under stall/bubble control.
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   d_valid, d_icode, d_ifun   D-stage instruction (valid flag, codes)
//   d_rA, d_rB, d_valC, d_valP D-stage register fields, constant, incremented PC
//   stall, bubble              E register hold / nop insertion (stall wins)
//   w_dstE/w_valE, w_dstM/w_valM  writeback ports (RNONE = no write, M wins on same id)
//   e_*                        registered D->E pipeline register outputs
module y86_decode_stage #(
    parameter int unsigned     DATA_W = 64,
    parameter int unsigned     NREGS  = 15,
    parameter int unsigned     RID_W  = 4,
    parameter logic [RID_W-1:0] RNONE = RID_W'(15),
    parameter logic [RID_W-1:0] RSP   = RID_W'(4)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              d_valid,
    input  logic [3:0]        d_icode,
    input  logic [3:0]        d_ifun,
    input  logic [RID_W-1:0]  d_rA,
    input  logic [RID_W-1:0]  d_rB,
    input  logic [DATA_W-1:0] d_valC,
    input  logic [DATA_W-1:0] d_valP,
    input  logic              stall,
    input  logic              bubble,
    input  logic [RID_W-1:0]  w_dstE,
    input  logic [DATA_W-1:0] w_valE,
    input  logic [RID_W-1:0]  w_dstM,
    input  logic [DATA_W-1:0] w_valM,
    output logic              e_valid,
    output logic [3:0]        e_icode,
    output logic [3:0]        e_ifun,
    output logic [DATA_W-1:0] e_valA,
    output logic [DATA_W-1:0] e_valB,
    output logic [DATA_W-1:0] e_valC,
    output logic [RID_W-1:0]  e_srcA,
    output logic [RID_W-1:0]  e_srcB,
    output logic [RID_W-1:0]  e_dstE,
    output logic [RID_W-1:0]  e_dstM,
    output logic              e_inv
);

    localparam logic [3:0] ICODE_NOP = 4'd1;

    logic [DATA_W-1:0] r_regs [NREGS];

    logic [RID_W-1:0]  w_src_a;
    logic [RID_W-1:0]  w_src_b;
    logic [RID_W-1:0]  w_dst_e;
    logic [RID_W-1:0]  w_dst_m;
    logic              w_inv;
    logic [DATA_W-1:0] w_rf_a;
    logic [DATA_W-1:0] w_rf_b;
    logic [DATA_W-1:0] w_byp_a;
    logic [DATA_W-1:0] w_byp_b;
    logic [DATA_W-1:0] w_val_a;

    logic              r_e_valid;
    logic [3:0]        r_e_icode;
    logic [3:0]        r_e_ifun;
    logic [DATA_W-1:0] r_e_val_a;
    logic [DATA_W-1:0] r_e_val_b;
    logic [DATA_W-1:0] r_e_val_c;
    logic [RID_W-1:0]  r_e_src_a;
    logic [RID_W-1:0]  r_e_src_b;
    logic [RID_W-1:0]  r_e_dst_e;
    logic [RID_W-1:0]  r_e_dst_m;
    logic              r_e_inv;

    // Register-id selection. cmov (icode 2) always names rB as dstE; the condition is
    // resolved in execute, which cancels the write there.
    always_comb begin
        w_src_a = RNONE;
        w_src_b = RNONE;
        w_dst_e = RNONE;
        w_dst_m = RNONE;
        w_inv   = 1'b0;
        case (d_icode)
            4'd2:    begin w_src_a = d_rA;                  w_dst_e = d_rB; end
            4'd3:    begin                                  w_dst_e = d_rB; end
            4'd4:    begin w_src_a = d_rA; w_src_b = d_rB;                  end
            4'd5:    begin w_src_b = d_rB;                  w_dst_m = d_rA; end
            4'd6:    begin w_src_a = d_rA; w_src_b = d_rB;  w_dst_e = d_rB; end
            4'd8:    begin w_src_b = RSP;                   w_dst_e = RSP;  end
            4'd9:    begin w_src_a = RSP;  w_src_b = RSP;   w_dst_e = RSP;  end
            4'd10:   begin w_src_a = d_rA; w_src_b = RSP;   w_dst_e = RSP;  end
            4'd11:   begin
                w_src_a = RSP;
                w_src_b = RSP;
                w_dst_e = RSP;
                w_dst_m = d_rA;
            end
            4'd12, 4'd13, 4'd14, 4'd15: w_inv = 1'b1;
            default: ;
        endcase
    end

    // Array read; ids outside 0..NREGS-1 (including RNONE) fall through to 0.
    always_comb begin
        w_rf_a = '0;
        w_rf_b = '0;
        for (int i = 0; i < int'(NREGS); i++) begin
            if (w_src_a == RID_W'(i) && w_src_a != RNONE) w_rf_a = r_regs[i];
            if (w_src_b == RID_W'(i) && w_src_b != RNONE) w_rf_b = r_regs[i];
        end
    end

    // Bypass: the M port has priority, matching the write priority below.
    always_comb begin
        w_byp_a = w_rf_a;
        w_byp_b = w_rf_b;
        if (w_src_a != RNONE && w_src_a == w_dstM)      w_byp_a = w_valM;
        else if (w_src_a != RNONE && w_src_a == w_dstE) w_byp_a = w_valE;
        if (w_src_b != RNONE && w_src_b == w_dstM)      w_byp_b = w_valM;
        else if (w_src_b != RNONE && w_src_b == w_dstE) w_byp_b = w_valE;
    end

    // call/jXX carry the return/fall-through address in valA
    assign w_val_a = (d_icode == 4'd7 || d_icode == 4'd8) ? d_valP : w_byp_a;

    // Register file writes; never stalled. Same-id collision keeps valM (popq %rsp).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NREGS); i++) r_regs[i] <= '0;
        end else begin
            for (int i = 0; i < int'(NREGS); i++) begin
                if (w_dstM == RID_W'(i))      r_regs[i] <= w_valM;
                else if (w_dstE == RID_W'(i)) r_regs[i] <= w_valE;
            end
        end
    end

    // D->E pipeline register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_e_valid <= 1'b0;
            r_e_icode <= ICODE_NOP;
            r_e_ifun  <= 4'd0;
            r_e_val_a <= '0;
            r_e_val_b <= '0;
            r_e_val_c <= '0;
            r_e_src_a <= RNONE;
            r_e_src_b <= RNONE;
            r_e_dst_e <= RNONE;
            r_e_dst_m <= RNONE;
            r_e_inv   <= 1'b0;
        end else if (stall) begin
            // hold
        end else if (bubble || !d_valid) begin
            r_e_valid <= 1'b0;
            r_e_icode <= ICODE_NOP;
            r_e_ifun  <= 4'd0;
            r_e_val_a <= '0;
            r_e_val_b <= '0;
            r_e_val_c <= '0;
            r_e_src_a <= RNONE;
            r_e_src_b <= RNONE;
            r_e_dst_e <= RNONE;
            r_e_dst_m <= RNONE;
            r_e_inv   <= 1'b0;
        end else begin
            r_e_valid <= 1'b1;
            r_e_icode <= d_icode;
            r_e_ifun  <= d_ifun;
            r_e_val_a <= w_val_a;
            r_e_val_b <= w_byp_b;
            r_e_val_c <= d_valC;
            r_e_src_a <= w_src_a;
            r_e_src_b <= w_src_b;
            r_e_dst_e <= w_dst_e;
            r_e_dst_m <= w_dst_m;
            r_e_inv   <= w_inv;
        end
    end

    assign e_valid = r_e_valid;
    assign e_icode = r_e_icode;
    assign e_ifun  = r_e_ifun;
    assign e_valA  = r_e_val_a;
    assign e_valB  = r_e_val_b;
    assign e_valC  = r_e_val_c;
    assign e_srcA  = r_e_src_a;
    assign e_srcB  = r_e_src_b;
    assign e_dstE  = r_e_dst_e;
    assign e_dstM  = r_e_dst_m;
    assign e_inv   = r_e_inv;

endmodule

// File: tb/tb_y86_decode_stage.sv
// tb_y86_decode_stage
//   Directed bench for y86_decode_stage: hand-computed expectations checked with immediate
//   assertions after each clock edge.
module tb_y86_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        d_valid;
    logic [3:0]  d_icode;
    logic [3:0]  d_ifun;
    logic [3:0]  d_rA;
    logic [3:0]  d_rB;
    logic [63:0] d_valC;
    logic [63:0] d_valP;
    logic        stall;
    logic        bubble;
    logic [3:0]  w_dstE;
    logic [63:0] w_valE;
    logic [3:0]  w_dstM;
    logic [63:0] w_valM;
    logic        e_valid;
    logic [3:0]  e_icode;
    logic [3:0]  e_ifun;
    logic [63:0] e_valA;
    logic [63:0] e_valB;
    logic [63:0] e_valC;
    logic [3:0]  e_srcA;
    logic [3:0]  e_srcB;
    logic [3:0]  e_dstE;
    logic [3:0]  e_dstM;
    logic        e_inv;

    int n_tests = 0;
    int n_fail  = 0;

    y86_decode_stage dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .d_valid (d_valid),
        .d_icode (d_icode),
        .d_ifun  (d_ifun),
        .d_rA    (d_rA),
        .d_rB    (d_rB),
        .d_valC  (d_valC),
        .d_valP  (d_valP),
        .stall   (stall),
        .bubble  (bubble),
        .w_dstE  (w_dstE),
        .w_valE  (w_valE),
        .w_dstM  (w_dstM),
        .w_valM  (w_valM),
        .e_valid (e_valid),
        .e_icode (e_icode),
        .e_ifun  (e_ifun),
        .e_valA  (e_valA),
        .e_valB  (e_valB),
        .e_valC  (e_valC),
        .e_srcA  (e_srcA),
        .e_srcB  (e_srcB),
        .e_dstE  (e_dstE),
        .e_dstM  (e_dstM),
        .e_inv   (e_inv)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic no_wb();
        w_dstE = 4'hF;
        w_valE = '0;
        w_dstM = 4'hF;
        w_valM = '0;
    endtask

    task automatic decode(input logic [3:0] icode, input logic [3:0] ra, input logic [3:0] rb);
        d_valid = 1'b1;
        d_icode = icode;
        d_ifun  = 4'd0;
        d_rA    = ra;
        d_rB    = rb;
    endtask

    initial begin
        d_valid = 1'b0; d_icode = 4'd0; d_ifun = 4'd0; d_rA = 4'hF; d_rB = 4'hF;
        d_valC = '0; d_valP = '0; stall = 1'b0; bubble = 1'b0;
        no_wb();

        // Asynchronous reset, checked before any clock edge
        #2 rst_n = 1'b0;
        #1;
        check("rst_valid", 64'(e_valid), 64'h0);
        check("rst_icode", 64'(e_icode), 64'h1);
        check("rst_valA",  e_valA, 64'h0);
        check("rst_srcA",  64'(e_srcA), 64'hF);
        check("rst_dstM",  64'(e_dstM), 64'hF);
        check("rst_inv",   64'(e_inv), 64'h0);
        #3 rst_n = 1'b1;

        // Write r3 = 0x55, no instruction
        w_dstE = 4'd3; w_valE = 64'h55;
        step();
        check("nop_valid", 64'(e_valid), 64'h0);
        no_wb();

        // cmov rA=3 rB=7 reads r3 from array
        decode(4'd2, 4'd3, 4'd7);
        step();
        check("cmov_valA",  e_valA, 64'h55);
        check("cmov_dstE",  64'(e_dstE), 64'h7);
        check("cmov_srcB",  64'(e_srcB), 64'hF);
        check("cmov_srcA",  64'(e_srcA), 64'h3);
        check("cmov_valid", 64'(e_valid), 64'h1);

        // OPq rA=rB=2 with same-cycle M writeback to r2 -> bypass on both operands
        w_dstM = 4'd2; w_valM = 64'hAA;
        decode(4'd6, 4'd2, 4'd2);
        step();
        check("byp_valA", e_valA, 64'hAA);
        check("byp_valB", e_valB, 64'hAA);
        check("byp_dstE", 64'(e_dstE), 64'h2);
        no_wb();

        // E and M both write RSP: M value must stick
        d_valid = 1'b0;
        w_dstE = 4'd4; w_valE = 64'h10; w_dstM = 4'd4; w_valM = 64'h20;
        step();
        no_wb();
        decode(4'd9, 4'hF, 4'hF);
        step();
        check("ret_valA_rsp", e_valA, 64'h20);
        check("ret_valB_rsp", e_valB, 64'h20);
        check("ret_dstE",     64'(e_dstE), 64'h4);

        // RSP = 0x100, then call with valP
        d_valid = 1'b0;
        w_dstE = 4'd4; w_valE = 64'h100;
        step();
        no_wb();
        decode(4'd8, 4'hF, 4'hF);
        d_valP = 64'h1234;
        step();
        check("call_valA", e_valA, 64'h1234);
        check("call_valB", e_valB, 64'h100);
        check("call_dstE", 64'(e_dstE), 64'h4);
        check("call_dstM", 64'(e_dstM), 64'hF);
        check("call_srcA", 64'(e_srcA), 64'hF);

        // popq rA=5, then stall three cycles with different inputs and a writeback to r5
        decode(4'd11, 4'd5, 4'hF);
        step();
        check("pop_icode", 64'(e_icode), 64'hB);
        check("pop_valA",  e_valA, 64'h100);
        check("pop_dstM",  64'(e_dstM), 64'h5);
        stall = 1'b1;
        decode(4'd6, 4'd3, 4'd2);
        w_dstE = 4'd5; w_valE = 64'h77;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_icode", 64'(e_icode), 64'hB);
            check("stall_dstM",  64'(e_dstM), 64'h5);
            check("stall_valA",  e_valA, 64'h100);
        end
        no_wb();
        bubble = 1'b1;
        step();
        check("stallbub_icode", 64'(e_icode), 64'hB);
        check("stallbub_valid", 64'(e_valid), 64'h1);

        // Bubble alone
        stall = 1'b0;
        step();
        check("bub_icode", 64'(e_icode), 64'h1);
        check("bub_valid", 64'(e_valid), 64'h0);
        check("bub_dstE",  64'(e_dstE), 64'hF);
        check("bub_srcA",  64'(e_srcA), 64'hF);
        bubble = 1'b0;

        // Write performed during the stall must be visible
        decode(4'd2, 4'd5, 4'd1);
        step();
        check("stallwr_valA", e_valA, 64'h77);

        // Illegal icode
        decode(4'd13, 4'd3, 4'd2);
        step();
        check("inv_flag",  64'(e_inv), 64'h1);
        check("inv_icode", 64'(e_icode), 64'hD);
        check("inv_srcA",  64'(e_srcA), 64'hF);
        check("inv_srcB",  64'(e_srcB), 64'hF);
        check("inv_dstE",  64'(e_dstE), 64'hF);
        check("inv_dstM",  64'(e_dstM), 64'hF);

        // irmovq and mrmovq
        decode(4'd3, 4'hF, 4'd1);
        d_valC = 64'hDEAD;
        step();
        check("irm_valC", e_valC, 64'hDEAD);
        check("irm_dstE", 64'(e_dstE), 64'h1);
        check("irm_valA", e_valA, 64'h0);
        check("irm_inv",  64'(e_inv), 64'h0);
        decode(4'd5, 4'd6, 4'd3);
        step();
        check("mrm_valB", e_valB, 64'h55);
        check("mrm_dstM", 64'(e_dstM), 64'h6);
        check("mrm_dstE", 64'(e_dstE), 64'hF);

        // Mid-run reset; writeback presented during reset is lost
        #2 rst_n = 1'b0;
        #1;
        check("mrst_icode", 64'(e_icode), 64'h1);
        check("mrst_valB",  e_valB, 64'h0);
        check("mrst_valid", 64'(e_valid), 64'h0);
        w_dstE = 4'd3; w_valE = 64'h99;
        step();
        no_wb();
        #2 rst_n = 1'b1;
        decode(4'd2, 4'd3, 4'd4);
        step();
        check("mrst_r3", e_valA, 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
